wb_stage_multi: RTL
===================

// Module: wb_stage_multi
// PURPOSE
//  Parametrised multi-lane write-back stage. Selects ALU or aligned/extended load data per lane,
//  resolves same-destination conflicts, registers results into the register-file write pipe
//  register, and keeps a short history of retired writes for ID-stage forwarding lookups.
//  Sits between MEM and the register file; replaces the single-lane WB stage.
// PARAMETERS
//  LANES       2  number of write-back lanes (1..4); lane i occupies bits [i*W +: W] of packed ports
//  REG_AW      5  register address width
//  HIST_DEPTH  2  retired-write history entries (1..4)
//  NUM_LOOKUP  2  forwarding lookup ports
// PORTS
//  CLK                 in   1               clock, all state on rising edge
//  RESET               in   1               synchronous, active-high reset
//  FREEZE              in   1               hold all state (PR and history)
//  do_writeback        in   LANES           per-lane write enable from MEM
//  writeRegister       in   LANES*REG_AW    per-lane destination
//  aluResult           in   LANES*32        per-lane ALU result (also load address)
//  Data_input          in   LANES*32        per-lane raw memory word
//  MemtoReg            in   LANES           1 = select load data
//  mem_size            in   LANES*2         00 byte, 01 half, 10 word, 11 treated as word
//  mem_signed          in   LANES           1 = sign-extend sub-word load
//  writeData_OUT       out  LANES*32        combinational selected data
//  do_writeback_OUT    out  LANES           combinational effective enable (after squash)
//  writeRegister_OUT   out  LANES*REG_AW    passthrough of writeRegister
//  writeData_PR        out  LANES*32        registered data to register file
//  writeRegister_PR    out  LANES*REG_AW    registered destination
//  do_writeback_PR     out  LANES           registered effective enable
//  lookup_reg          in   NUM_LOOKUP*REG_AW  forwarding query addresses
//  lookup_hit          out  NUM_LOOKUP      comb: matching write found in PR or history
//  lookup_data         out  NUM_LOOKUP*32   comb: data of newest match, 0 on miss
// BEHAVIOUR
//  - Load align (big-endian, off = aluResult[1:0]): byte -> byte at bits [31-8*off -: 8];
//    half -> off[1]=0 ? [31:16] : [15:0] (off[0] ignored); word -> whole word.
//    Sub-word zero- or sign-extended per mem_signed. MemtoReg=0 -> aluResult unchanged.
//  - Effective enable: do_writeback & (writeRegister != 0). Register 0 never written.
//  - Conflict: if lanes i<j both effective to same register, lane i squashed (j = program-later wins).
//  - Pipe register: on rising CLK, RESET=1 -> all PR outputs 0; else if !FREEZE -> PR <= OUT values;
//    FREEZE=1 -> PR holds. Latency 1 cycle from inputs to PR.
//  - History: on each non-frozen, non-reset edge, current PR lanes with do_writeback_PR=1 shift into
//    history as newest group; oldest group (HIST_DEPTH back) drops. Entry = {valid, reg, data} per lane.
//    RESET clears all valid bits and data to 0 in the same edge as PR. FREEZE holds history.
//  - Lookup priority: PR (highest lane first), then history newest->oldest, highest lane first within
//    a group. lookup_reg==0 -> hit=0, data=0. Lookup is purely combinational, never stalls.
//  - Reset mid-stream: inputs presented in the reset cycle are discarded; first post-reset edge loads
//    normally. FREEZE and RESET together -> RESET wins.
//  - No handshake: caller guarantees inputs stable while FREEZE=1.
// STRUCTURE
//  - Package wb_pkg: DATA_W=32 constant, mem_size enum (SZ_BYTE/SZ_HALF/SZ_WORD), history entry struct.
//  - Sub-module wb_load_align: one instance per lane (data, off, size, signed -> 32b result).
//  - Top holds squash logic, PR flops, history shift array, lookup mux.
// TESTING
//  1 Reset: RESET=1 one edge with all inputs busy -> all PR 0, lookup_hit=0 for every register.
//  2 Align: Data_input=32'h8091A2B3, MemtoReg=1: byte off=1 signed -> FFFFFF91; half off=2 unsigned
//    -> 0000A2B3; half off=0 signed -> FFFF8091; word -> 8091A2B3.
//  3 Conflict: lane0 and lane1 both write r7 (11, 22) -> do_writeback_PR=2'b10, r7 lookup -> 22.
//  4 Zero reg: lane0 writes r0 with 0xDEAD -> do_writeback_OUT[0]=0, lookup r0 hit=0.
//  5 History/freeze: write r3=5 then r3=9 then idle 1 cycle -> lookup r3=9; FREEZE 3 cycles with new
//    inputs -> PR and lookup unchanged; after HIST_DEPTH+1 idle edges -> r3 hit=0.
//  6 FREEZE+RESET same edge -> all state cleared.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the multi-lane write-back stage: data width, load size codes
// and the retired-write history entry.
package wb_pkg;
  localparam int DATA_W     = 32;
  // History entries store the destination at a fixed width; REG_AW must not exceed this.
  localparam int REG_AW_MAX = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rg;
    logic [DATA_W-1:0]     data;
  } hist_entry_t;
endpackage

// File: rtl/wb_load_align.sv
// Big-endian load alignment for one lane: picks the addressed byte/half from the
// raw memory word and zero- or sign-extends it.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] result_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (off_i)
      2'd0:    byte_v = data_i[31:24];
      2'd1:    byte_v = data_i[23:16];
      2'd2:    byte_v = data_i[15:8];
      default: byte_v = data_i[7:0];
    endcase
    half_v = off_i[1] ? data_i[15:0] : data_i[31:16];
    case (mem_size_e'(size_i))
      SZ_BYTE: result_o = {{24{signed_i & byte_v[7]}}, byte_v};
      SZ_HALF: result_o = {{16{signed_i & half_v[15]}}, half_v};
      default: result_o = data_i; // size 11 behaves as a full word
    endcase
  end
endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane write-back stage: data select, same-destination squash, write pipe
// register, retired-write history and combinational forwarding lookup.
module wb_stage_multi
  import wb_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 2,
  parameter int NUM_LOOKUP = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         FREEZE,
  input  logic [LANES-1:0]             do_writeback,
  input  logic [LANES*REG_AW-1:0]      writeRegister,
  input  logic [LANES*DATA_W-1:0]      aluResult,
  input  logic [LANES*DATA_W-1:0]      Data_input,
  input  logic [LANES-1:0]             MemtoReg,
  input  logic [LANES*2-1:0]           mem_size,
  input  logic [LANES-1:0]             mem_signed,
  output logic [LANES*DATA_W-1:0]      writeData_OUT,
  output logic [LANES-1:0]             do_writeback_OUT,
  output logic [LANES*REG_AW-1:0]      writeRegister_OUT,
  output logic [LANES*DATA_W-1:0]      writeData_PR,
  output logic [LANES*REG_AW-1:0]      writeRegister_PR,
  output logic [LANES-1:0]             do_writeback_PR,
  input  logic [NUM_LOOKUP*REG_AW-1:0] lookup_reg,
  output logic [NUM_LOOKUP-1:0]        lookup_hit,
  output logic [NUM_LOOKUP*DATA_W-1:0] lookup_data
);
  logic [LANES-1:0][REG_AW-1:0] wreg;
  logic [LANES-1:0][DATA_W-1:0] alu, din, aligned, data_d, data_q;
  logic [LANES-1:0][1:0]        msz;
  logic [LANES-1:0][REG_AW-1:0] reg_q;
  logic [LANES-1:0]             eff, we_d, we_q;

  hist_entry_t [HIST_DEPTH-1:0][LANES-1:0] hist_q;

  logic [NUM_LOOKUP-1:0][REG_AW-1:0] lreg;
  logic [NUM_LOOKUP-1:0][DATA_W-1:0] ldata;

  assign wreg = writeRegister;
  assign alu  = aluResult;
  assign din  = Data_input;
  assign msz  = mem_size;
  assign lreg = lookup_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    wb_load_align u_align (
      .data_i   (din[gi]),
      .off_i    (alu[gi][1:0]),
      .size_i   (msz[gi]),
      .signed_i (mem_signed[gi]),
      .result_o (aligned[gi])
    );
    assign data_d[gi] = MemtoReg[gi] ? aligned[gi] : alu[gi];
    assign eff[gi]    = do_writeback[gi] & (wreg[gi] != '0);
  end

  // A higher lane is program-later, so it wins any same-destination conflict.
  always_comb begin
    we_d = eff;
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (eff[i] && eff[j] && wreg[i] == wreg[j]) we_d[i] = 1'b0;
  end

  assign writeData_OUT     = data_d;
  assign do_writeback_OUT  = we_d;
  assign writeRegister_OUT = writeRegister;
  assign writeData_PR      = data_q;
  assign writeRegister_PR  = reg_q;
  assign do_writeback_PR   = we_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q <= '0;
      reg_q  <= '0;
      we_q   <= '0;
      hist_q <= '0;
    end else if (!FREEZE) begin
      data_q <= data_d;
      reg_q  <= wreg;
      we_q   <= we_d;
      for (int k = HIST_DEPTH - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
      for (int l = 0; l < LANES; l++) begin
        hist_q[0][l].valid <= we_q[l];
        hist_q[0][l].rg    <= REG_AW_MAX'(reg_q[l]);
        hist_q[0][l].data  <= data_q[l];
      end
    end
  end

  // Scan lowest priority first so later matches override: oldest history up to PR top lane.
  always_comb begin
    lookup_hit = '0;
    ldata      = '0;
    for (int p = 0; p < NUM_LOOKUP; p++) begin
      for (int k = HIST_DEPTH - 1; k >= 0; k--)
        for (int l = 0; l < LANES; l++)
          if (hist_q[k][l].valid && hist_q[k][l].rg == REG_AW_MAX'(lreg[p])) begin
            lookup_hit[p] = 1'b1;
            ldata[p]      = hist_q[k][l].data;
          end
      for (int l = 0; l < LANES; l++)
        if (we_q[l] && reg_q[l] == lreg[p]) begin
          lookup_hit[p] = 1'b1;
          ldata[p]      = data_q[l];
        end
      if (lreg[p] == '0) begin
        lookup_hit[p] = 1'b0;
        ldata[p]      = '0;
      end
    end
  end

  assign lookup_data = ldata;
endmodule
